// File: rtl/mem_bank_scanner.sv
// mem_bank_scanner: read-side sequencer for a multi-bank memory.
// It walks every (bank, addr) pair in bank-major order and tags each read.
// The tags are realigned with the delayed read data.
// Results are buffered in a first-word-fall-through FIFO behind a valid/ready stream.
// The FIFO overflow check lives in mem_bank_scanner_chk.

module mem_bank_scanner_chk #(
   parameter int FIFO_DEPTH = 4,
   parameter int CW         = 4
) (
   input logic          clk,
   input logic          reset_n,
   input logic          push,
   input logic          pop,
   input logic [CW-1:0] count
);
   // A push into a full FIFO without a simultaneous pop means the credit scheme is broken.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (!(push && !pop && (count == CW'(FIFO_DEPTH))));
      end
   end
endmodule

module mem_bank_scanner #(
   parameter int DATA_WIDTH   = 16,
   parameter int DEPTH        = 18,
   parameter int NUM_BANKS    = 2,
   parameter int BANK_WIDTH   = $clog2(NUM_BANKS),
   parameter int OUTPUT_DELAY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     reb,
   output logic [BANK_WIDTH-1:0]    bankb,
   output logic [$clog2(DEPTH)-1:0] addrb,
   input  logic [DATA_WIDTH-1:0]    dob,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [BANK_WIDTH-1:0]    out_bank,
   output logic [$clog2(DEPTH)-1:0] out_addr,
   output logic                     out_last
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + OUTPUT_DELAY + 2) + 1;
   localparam logic [BANK_WIDTH-1:0] LAST_BANK  = BANK_WIDTH'(NUM_BANKS - 1);
   localparam logic [AW-1:0]         LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [CW-1:0]         CREDIT_MAX = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                state_r;
   logic                  busy_r;
   logic                  reb_r;
   logic                  iss_last_r;
   logic [BANK_WIDTH-1:0] bankb_r;
   logic [AW-1:0]         addrb_r;
   logic [BANK_WIDTH-1:0] bank_r;
   logic [AW-1:0]         addr_r;

   logic                  pipe_vld_r  [OUTPUT_DELAY];
   logic                  pipe_last_r [OUTPUT_DELAY];
   logic [BANK_WIDTH-1:0] pipe_bank_r [OUTPUT_DELAY];
   logic [AW-1:0]         pipe_addr_r [OUTPUT_DELAY];

   logic [DATA_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
   logic [BANK_WIDTH-1:0] fifo_bank_r [FIFO_DEPTH];
   logic [AW-1:0]         fifo_addr_r [FIFO_DEPTH];
   logic                  fifo_last_r [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;

   logic [CW-1:0]         inflight_s;
   logic                  credit_s;
   logic                  issue_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  head_vld_s;
   logic                  done_s;
   logic [BANK_WIDTH-1:0] cur_bank_s;
   logic [AW-1:0]         cur_addr_s;
   logic                  cur_last_s;
   logic [BANK_WIDTH-1:0] nxt_bank_s;
   logic [AW-1:0]         nxt_addr_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credit check, the next word to request, and the counter advance.
   always_comb begin
      inflight_s = CW'(reb_r);
      for (int i = 0; i < OUTPUT_DELAY; i++) begin
         inflight_s = inflight_s + CW'(pipe_vld_r[i]);
      end
      head_vld_s = (count_r != '0);
      pop_s      = head_vld_s && out_ready;
      push_s     = pipe_vld_r[OUTPUT_DELAY-1];
      // A word leaving this cycle frees its slot for the request issued now.
      credit_s   = ((inflight_s + count_r - CW'(pop_s)) < CREDIT_MAX);
      done_s     = (state_r == ST_DRAIN) && pop_s && fifo_last_r[rd_ptr_r];

      if (state_r == ST_IDLE) begin
         cur_bank_s = '0;
         cur_addr_s = '0;
         issue_s    = start && credit_s;
      end else if (state_r == ST_SCAN) begin
         cur_bank_s = bank_r;
         cur_addr_s = addr_r;
         issue_s    = credit_s;
      end else begin
         cur_bank_s = bank_r;
         cur_addr_s = addr_r;
         issue_s    = 1'b0;
      end

      cur_last_s = (cur_bank_s == LAST_BANK) && (cur_addr_s == LAST_ADDR);
      if (cur_last_s) begin
         nxt_bank_s = '0;
         nxt_addr_s = '0;
      end else if (cur_addr_s == LAST_ADDR) begin
         nxt_bank_s = cur_bank_s + BANK_WIDTH'(1);
         nxt_addr_s = '0;
      end else begin
         nxt_bank_s = cur_bank_s;
         nxt_addr_s = cur_addr_s + AW'(1);
      end
   end

   // Sequencer FSM: owns the scan counters, the memory read port and busy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         busy_r     <= 1'b0;
         reb_r      <= 1'b0;
         iss_last_r <= 1'b0;
         bankb_r    <= '0;
         addrb_r    <= '0;
         bank_r     <= '0;
         addr_r     <= '0;
      end else begin
         reb_r <= issue_s;
         if (issue_s) begin
            bankb_r    <= cur_bank_s;
            addrb_r    <= cur_addr_s;
            iss_last_r <= cur_last_s;
            bank_r     <= nxt_bank_s;
            addr_r     <= nxt_addr_s;
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r <= ST_SCAN;
                  busy_r  <= 1'b1;
                  if (!issue_s) begin
                     bank_r <= '0;
                     addr_r <= '0;
                  end
               end
            end
            ST_SCAN: begin
               if (issue_s && cur_last_s) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (done_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Tag pipe: delays the request tags to line up with the memory read latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < OUTPUT_DELAY; i++) begin
            pipe_vld_r[i]  <= 1'b0;
            pipe_last_r[i] <= 1'b0;
            pipe_bank_r[i] <= '0;
            pipe_addr_r[i] <= '0;
         end
      end else begin
         pipe_vld_r[0]  <= reb_r;
         pipe_last_r[0] <= iss_last_r;
         pipe_bank_r[0] <= bankb_r;
         pipe_addr_r[0] <= addrb_r;
         for (int i = 1; i < OUTPUT_DELAY; i++) begin
            pipe_vld_r[i]  <= pipe_vld_r[i-1];
            pipe_last_r[i] <= pipe_last_r[i-1];
            pipe_bank_r[i] <= pipe_bank_r[i-1];
            pipe_addr_r[i] <= pipe_addr_r[i-1];
         end
      end
   end

   // Output FIFO: capture aligned data with its tags, release on valid & ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_r[i] <= '0;
            fifo_bank_r[i] <= '0;
            fifo_addr_r[i] <= '0;
            fifo_last_r[i] <= 1'b0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            fifo_data_r[wr_ptr_r] <= dob;
            fifo_bank_r[wr_ptr_r] <= pipe_bank_r[OUTPUT_DELAY-1];
            fifo_addr_r[wr_ptr_r] <= pipe_addr_r[OUTPUT_DELAY-1];
            fifo_last_r[wr_ptr_r] <= pipe_last_r[OUTPUT_DELAY-1];
            wr_ptr_r              <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_s;
   assign reb       = reb_r;
   assign bankb     = bankb_r;
   assign addrb     = addrb_r;
   assign out_valid = head_vld_s;
   assign out_data  = head_vld_s ? fifo_data_r[rd_ptr_r] : '0;
   assign out_bank  = head_vld_s ? fifo_bank_r[rd_ptr_r] : '0;
   assign out_addr  = head_vld_s ? fifo_addr_r[rd_ptr_r] : '0;
   assign out_last  = head_vld_s ? fifo_last_r[rd_ptr_r] : 1'b0;

   mem_bank_scanner_chk #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CW         (CW)
   ) u_chk (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .pop     (pop_s),
      .count   (count_r)
   );
endmodule

// File: tb/tb_mem_bank_scanner.sv
// Bench for mem_bank_scanner: two instances, read latency 1 and 2, share the stimulus.
// Each instance has its own memory model preloaded with bank*256+addr.
module tb_mem_bank_scanner;
   localparam int DW    = 16;
   localparam int DEPTH = 18;
   localparam int NB    = 2;
   localparam int FD    = 4;
   localparam int BW    = 1;
   localparam int AW    = 5;
   localparam int NW    = NB * DEPTH;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic out_ready = 1'b0;
   always #5 clk = ~clk;

   logic          busy_w [2];
   logic          done_w [2];
   logic          reb_w [2];
   logic          out_valid_w [2];
   logic          out_last_w [2];
   logic [BW-1:0] bankb_w [2];
   logic [BW-1:0] out_bank_w [2];
   logic [AW-1:0] addrb_w [2];
   logic [AW-1:0] out_addr_w [2];
   logic [DW-1:0] dob_w [2];
   logic [DW-1:0] out_data_w [2];

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input int g, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s (delay %0d): observed=%0h expected=%0h", tag, g + 1, obs, exp_v);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [DW-1:0] q1 = '0;
      logic [DW-1:0] q2 = '0;
      mem_bank_scanner #(
         .DATA_WIDTH   (DW),
         .DEPTH        (DEPTH),
         .NUM_BANKS    (NB),
         .OUTPUT_DELAY (g + 1),
         .FIFO_DEPTH   (FD)
      ) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .start     (start),
         .busy      (busy_w[g]),
         .done      (done_w[g]),
         .reb       (reb_w[g]),
         .bankb     (bankb_w[g]),
         .addrb     (addrb_w[g]),
         .dob       (dob_w[g]),
         .out_valid (out_valid_w[g]),
         .out_ready (out_ready),
         .out_data  (out_data_w[g]),
         .out_bank  (out_bank_w[g]),
         .out_addr  (out_addr_w[g]),
         .out_last  (out_last_w[g])
      );
      // Memory model: registered read, optional extra output stage.
      always @(posedge clk) begin
         if (reb_w[g]) q1 <= {7'd0, bankb_w[g], 8'd0} | {11'd0, addrb_w[g]};
         q2 <= q1;
      end
      assign dob_w[g] = (g == 0) ? q1 : q2;
   end

   // Reference: word k of a scan is bank k/DEPTH, addr k%DEPTH, data bank*256+addr.
   int k_r [2] = '{0, 0};
   int words [2] = '{0, 0};
   int dones [2] = '{0, 0};
   logic stall_q [2] = '{1'b0, 1'b0};
   logic [DW+BW+AW:0] held [2];

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         logic [DW+BW+AW:0] head, exp_head;
         logic pop;
         int eb, ea;
         if (!reset_n) begin
            k_r[g] = 0;
            stall_q[g] = 1'b0;
         end else begin
            head = {out_data_w[g], out_bank_w[g], out_addr_w[g], out_last_w[g]};
            if (stall_q[g]) begin
               chk("hold_valid", g, out_valid_w[g], 1);
               chk("hold_head", g, head, held[g]);
            end
            pop = out_valid_w[g] && out_ready;
            eb = k_r[g] / DEPTH;
            ea = k_r[g] % DEPTH;
            exp_head = {16'(eb * 256 + ea), eb[BW-1:0], ea[AW-1:0], (k_r[g] == NW - 1)};
            if (pop) begin
               chk("word", g, head, exp_head);
               words[g]++;
            end
            chk("done", g, done_w[g], pop && (k_r[g] == NW - 1));
            if (done_w[g]) dones[g]++;
            if (pop) k_r[g] = (k_r[g] == NW - 1) ? 0 : k_r[g] + 1;
            stall_q[g] = out_valid_w[g] && !out_ready;
            held[g] = head;
         end
      end
   end

   int snap_w [2];
   int snap_d [2];

   task automatic snap();
      for (int g = 0; g < 2; g++) begin
         snap_w[g] = words[g];
         snap_d[g] = dones[g];
      end
   endtask

   task automatic end_check(input string tag);
      for (int g = 0; g < 2; g++) begin
         chk({tag, "_words"}, g, words[g] - snap_w[g], NW);
         chk({tag, "_dones"}, g, dones[g] - snap_d[g], 1);
      end
   endtask

   task automatic all_zero(input string tag);
      for (int g = 0; g < 2; g++) begin
         chk(tag, g, {busy_w[g], done_w[g], reb_w[g], out_valid_w[g], out_last_w[g],
                      bankb_w[g], addrb_w[g], out_data_w[g], out_bank_w[g], out_addr_w[g]}, 0);
      end
   endtask

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int c = 0;
      while ((busy_w[0] || busy_w[1]) && c < limit) begin
         @(posedge clk); #1;
         c++;
      end
      chk("idle_timeout", 0, busy_w[0] | busy_w[1], 0);
   endtask

   initial begin
      int first_v [2];
      int done_n [2];
      int rebs [2];
      int c;

      // Reset state, while held and just after release.
      repeat (3) @(posedge clk);
      #1 all_zero("reset_held");
      reset_n = 1'b1;
      @(posedge clk); #1 all_zero("reset_release");

      // Full scan with out_ready high: latency, throughput, order, done timing.
      out_ready = 1'b1;
      snap();
      do_start();
      for (int g = 0; g < 2; g++) begin
         chk("start_busy", g, busy_w[g], 1);
         chk("start_reb", g, {reb_w[g], bankb_w[g], addrb_w[g]}, {1'b1, 1'b0, 5'd0});
         first_v[g] = -1;
         done_n[g] = -1;
      end
      for (int n = 0; n < 100 && (done_n[0] < 0 || done_n[1] < 0); n++) begin
         for (int g = 0; g < 2; g++) begin
            if (first_v[g] < 0 && out_valid_w[g]) first_v[g] = n;
            if (done_n[g] < 0 && done_w[g]) done_n[g] = n;
         end
         @(posedge clk); #1;
      end
      for (int g = 0; g < 2; g++) begin
         chk("first_valid_lat", g, first_v[g], g + 2);
         chk("done_lat", g, done_n[g], NW + g + 1);
      end
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) chk("busy_after_done", g, busy_w[g], 0);
      end_check("scan_ready");

      // Consumer stalled from start: exactly FD reads, then resume.
      out_ready = 1'b0;
      snap();
      do_start();
      rebs = '{0, 0};
      for (int n = 0; n < 20; n++) begin
         for (int g = 0; g < 2; g++) if (reb_w[g]) rebs[g]++;
         @(posedge clk); #1;
      end
      for (int g = 0; g < 2; g++) begin
         chk("stall_reads", g, rebs[g], FD);
         chk("stall_reb_low", g, reb_w[g], 0);
         chk("stall_valid", g, out_valid_w[g], 1);
      end
      out_ready = 1'b1;
      wait_idle(200);
      end_check("scan_stall");

      // Three scans with random backpressure.
      for (int s = 0; s < 3; s++) begin
         snap();
         do_start();
         c = 0;
         while ((busy_w[0] || busy_w[1]) && c < 1000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            c++;
         end
         out_ready = 1'b1;
         chk("rand_timeout", s, busy_w[0] | busy_w[1], 0);
         end_check("scan_rand");
      end

      // start while busy and in the done cycle is ignored.
      out_ready = 1'b1;
      snap();
      do_start();
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int g = 0; g < 2; g++) chk("restart_busy", g, busy_w[g], 1);
      c = 0;
      while (!done_w[0] && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      chk("done_seen", 0, done_w[0], 1);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("start_at_done", 0, busy_w[0], 0);
      wait_idle(20);
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) chk("no_rescan", g, busy_w[g], 0);
      end_check("scan_restart");

      // Reset at word 10, then a clean full scan.
      snap();
      do_start();
      c = 0;
      while ((words[0] - snap_w[0]) < 10 && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      chk("reach_word10", 0, words[0] - snap_w[0], 10);
      reset_n = 1'b0;
      #1 all_zero("mid_reset");
      @(posedge clk); #1 reset_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         all_zero("post_reset");
         @(posedge clk); #1;
      end
      snap();
      do_start();
      for (int g = 0; g < 2; g++)
         chk("rescan_first", g, {reb_w[g], bankb_w[g], addrb_w[g]}, {1'b1, 1'b0, 5'd0});
      wait_idle(200);
      end_check("scan_after_reset");

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
